// File: rtl/rs232_frame_receiver_pkg.sv
// rtl/rs232_frame_receiver_pkg.sv - shared types and helpers for the RS-232 frame receiver
package rs232_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        PAYLOAD,
        CHECK,
        HOLD
    } state_t;

    localparam logic [7:0] DEFAULT_SOF = 8'hA5;

    // Always returns at least 1 so a one-entry buffer still gets a 1-bit address.
    function automatic int clog2_f(input int v);
        int r;
        for (r = 1; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

    function automatic int timeout_ticks(input int clk_freq, input int baud, input int bits);
        return (clk_freq / baud) * bits;
    endfunction

endpackage

// File: rtl/rs232_frame_receiver_if.sv
// rtl/rs232_frame_receiver_if.sv - byte-in / frame-out signal bundle of the frame receiver
interface rs232_frame_receiver_if #(
    parameter int AW = 4
);
    logic [7:0]    rx_data;
    logic          rx_byte_received;
    logic          rx_err;
    logic          rx_read;
    logic          frame_ready;
    logic [7:0]    frame_len;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          frame_ack;
    logic          chk_err;
    logic          len_err;
    logic          line_err;
    logic          timeout_err;
    logic          overrun;

    modport master (
        output rx_data, rx_byte_received, rx_err, rd_addr, frame_ack,
        input  rx_read, frame_ready, frame_len, rd_data,
        input  chk_err, len_err, line_err, timeout_err, overrun
    );

    modport slave (
        input  rx_data, rx_byte_received, rx_err, rd_addr, frame_ack,
        output rx_read, frame_ready, frame_len, rd_data,
        output chk_err, len_err, line_err, timeout_err, overrun
    );
endinterface

// File: rtl/rs232_frame_receiver_buffer.sv
// rtl/rs232_frame_receiver_buffer.sv - payload RAM, one write port and a registered read port
module rs232_frame_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o
);
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i && !rst) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read-during-write to the same address returns the old contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= 8'd0;
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;
endmodule

// File: rtl/rs232_frame_receiver.sv
// rtl/rs232_frame_receiver.sv - assembles SOF/LEN/PAYLOAD/CHK frames from a UART byte stream
module rs232_frame_receiver
    import rs232_frame_pkg::*;
#(
    parameter int         CLK_FREQ     = 50000000,
    parameter int         BAUD_RATE    = 115200,
    parameter int         MAX_PAYLOAD  = 16,
    parameter logic [7:0] SOF_BYTE     = DEFAULT_SOF,
    parameter int         TIMEOUT_BITS = 20
) (
    input logic                   clk,
    input logic                   rst,
    rs232_frame_receiver_if.slave bus
);
    localparam int AW    = clog2_f(MAX_PAYLOAD);
    localparam int TICKS = timeout_ticks(CLK_FREQ, BAUD_RATE, TIMEOUT_BITS);
    localparam int CW    = clog2_f(TICKS);

    state_t        state_q, state_d;
    logic [7:0]    len_q, len_d, chk_q, chk_d, flen_q, flen_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rx_read_q, chk_err_q, len_err_q, line_err_q, tmo_err_q, overrun_q;
    logic          chk_err_d, len_err_d, line_err_d, tmo_err_d, overrun_d;
    logic          wr_en;

    logic byte_v, err_v, ack_v, active, tmo, len_bad, last_payload;
    assign byte_v       = bus.rx_byte_received;
    assign err_v        = bus.rx_err;
    assign ack_v        = (state_q == HOLD) && bus.frame_ack;
    assign active       = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHECK);
    assign tmo          = active && !byte_v && (cnt_q == CW'(TICKS - 1));
    assign len_bad      = (bus.rx_data == 8'd0) || (32'(bus.rx_data) > MAX_PAYLOAD);
    assign last_payload = (idx_q == AW'(len_q - 8'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (byte_v && !err_v && bus.rx_data == SOF_BYTE) state_d = LEN;
            LEN:     if (byte_v) state_d = (err_v || len_bad) ? IDLE : PAYLOAD;
                     else if (tmo) state_d = IDLE;
            PAYLOAD: if (byte_v) state_d = err_v ? IDLE : (last_payload ? CHECK : PAYLOAD);
                     else if (tmo) state_d = IDLE;
            CHECK:   if (byte_v) state_d = (!err_v && bus.rx_data == chk_q) ? HOLD : IDLE;
                     else if (tmo) state_d = IDLE;
            HOLD:    if (ack_v) state_d = (byte_v && !err_v && bus.rx_data == SOF_BYTE) ? LEN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        len_d      = len_q;
        chk_d      = chk_q;
        idx_d      = idx_q;
        flen_d     = flen_q;
        cnt_d      = (byte_v || !active) ? '0 : cnt_q + CW'(1);
        wr_en      = 1'b0;
        chk_err_d  = 1'b0;
        len_err_d  = 1'b0;
        line_err_d = 1'b0;
        tmo_err_d  = tmo;
        overrun_d  = 1'b0;
        if (byte_v && active && err_v) begin
            line_err_d = 1'b1;
        end else if (byte_v) begin
            case (state_q)
                LEN: begin
                    if (len_bad) begin
                        len_err_d = 1'b1;
                    end else begin
                        len_d = bus.rx_data;
                        chk_d = bus.rx_data;
                        idx_d = '0;
                    end
                end
                PAYLOAD: begin
                    wr_en = 1'b1;
                    chk_d = chk_q ^ bus.rx_data;
                    idx_d = idx_q + AW'(1);
                end
                CHECK: begin
                    if (bus.rx_data == chk_q) flen_d = len_q;
                    else chk_err_d = 1'b1;
                end
                HOLD:    overrun_d = !ack_v;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= 8'd0;
            chk_q      <= 8'd0;
            flen_q     <= 8'd0;
            idx_q      <= '0;
            cnt_q      <= '0;
            rx_read_q  <= 1'b0;
            chk_err_q  <= 1'b0;
            len_err_q  <= 1'b0;
            line_err_q <= 1'b0;
            tmo_err_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            len_q      <= len_d;
            chk_q      <= chk_d;
            flen_q     <= flen_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            rx_read_q  <= byte_v;
            chk_err_q  <= chk_err_d;
            len_err_q  <= len_err_d;
            line_err_q <= line_err_d;
            tmo_err_q  <= tmo_err_d;
            overrun_q  <= overrun_d;
        end
    end

    rs232_frame_buffer #(.DEPTH(MAX_PAYLOAD), .AW(AW)) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_addr_i (idx_q),
        .wr_data_i (bus.rx_data),
        .rd_addr_i (bus.rd_addr),
        .rd_data_o (bus.rd_data)
    );

    assign bus.rx_read     = rx_read_q;
    assign bus.frame_ready = (state_q == HOLD);
    assign bus.frame_len   = flen_q;
    assign bus.chk_err     = chk_err_q;
    assign bus.len_err     = len_err_q;
    assign bus.line_err    = line_err_q;
    assign bus.timeout_err = tmo_err_q;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_rs232_frame_receiver.sv
// tb/tb_rs232_frame_receiver.sv - directed bench with a byte-level frame model
module tb_rs232_frame_receiver;
    localparam int         MAXP  = 16;
    localparam int         TICKS = 8680;
    localparam logic [7:0] SOF   = 8'hA5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rs232_frame_receiver_if #(.AW(4)) bus();
    rs232_frame_receiver dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Frame model: bytes are collected per frame and judged as a whole.
    bit         m_on = 1'b0;
    bit         m_in = 1'b0;
    bit         m_held = 1'b0;
    int         m_gap = 0;
    logic [7:0] m_q[$];
    logic [7:0] m_mem[MAXP];
    bit         m_memv[MAXP];
    logic       e_read, e_ready, e_chk, e_len, e_line, e_tmo, e_ovr, e_rdk;
    logic [7:0] e_flen, e_rd;

    always @(posedge clk) begin
        logic [7:0] d, x;
        int n;
        if (rst) begin
            m_on = 1'b1; m_in = 1'b0; m_held = 1'b0; m_gap = 0;
            {e_read, e_chk, e_len, e_line, e_tmo, e_ovr} = '0;
            e_flen = 8'd0; e_rd = 8'd0; e_rdk = 1'b1;
        end else if (m_on) begin
            d = bus.rx_data;
            e_read = bus.rx_byte_received;
            {e_chk, e_len, e_line, e_tmo, e_ovr} = '0;
            e_rdk = m_memv[bus.rd_addr];
            if (e_rdk) e_rd = m_mem[bus.rd_addr];
            if (m_held && bus.frame_ack) m_held = 1'b0;
            if (m_in && !bus.rx_byte_received) begin
                m_gap++;
                if (m_gap == TICKS) begin e_tmo = 1'b1; m_in = 1'b0; end
            end
            if (bus.rx_byte_received) begin
                m_gap = 0;
                if (m_held) begin
                    e_ovr = 1'b1;
                end else if (!m_in) begin
                    if (!bus.rx_err && d == SOF) begin m_in = 1'b1; m_q.delete(); end
                end else if (bus.rx_err) begin
                    e_line = 1'b1; m_in = 1'b0;
                end else begin
                    m_q.push_back(d);
                    n = m_q.size();
                    if (n == 1) begin
                        if (d == 8'd0 || int'(d) > MAXP) begin e_len = 1'b1; m_in = 1'b0; end
                    end else if (n <= int'(m_q[0]) + 1) begin
                        m_mem[n-2] = d; m_memv[n-2] = 1'b1;
                    end else begin
                        x = 8'd0;
                        for (int i = 0; i < n - 1; i++) x ^= m_q[i];
                        if (d == x) begin m_held = 1'b1; e_flen = m_q[0]; end
                        else e_chk = 1'b1;
                        m_in = 1'b0;
                    end
                end
            end
        end
        e_ready = m_held;
    end

    int c_read = 0, c_chk = 0, c_len = 0, c_line = 0, c_tmo = 0, c_ovr = 0;

    always @(negedge clk) begin
        if (m_on) begin
            check("rx_read", bus.rx_read, e_read);
            check("frame_ready", bus.frame_ready, e_ready);
            check("chk_err", bus.chk_err, e_chk);
            check("len_err", bus.len_err, e_len);
            check("line_err", bus.line_err, e_line);
            check("timeout_err", bus.timeout_err, e_tmo);
            check("overrun", bus.overrun, e_ovr);
            if (e_ready) check("frame_len", bus.frame_len, e_flen);
            if (e_rdk) check("rd_data", bus.rd_data, e_rd);
            c_read += int'(bus.rx_read);
            c_chk  += int'(bus.chk_err);
            c_len  += int'(bus.len_err);
            c_line += int'(bus.line_err);
            c_tmo  += int'(bus.timeout_err);
            c_ovr  += int'(bus.overrun);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit e);
        bus.rx_data = d; bus.rx_err = e; bus.rx_byte_received = 1'b1;
        cyc();
        bus.rx_byte_received = 1'b0; bus.rx_err = 1'b0;
        cyc();
        cyc();
    endtask

    logic [7:0] seq[$];
    task automatic send_seq();
        foreach (seq[i]) send(seq[i], 1'b0);
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string name);
        bus.rd_addr = a;
        cyc();
        check(name, bus.rd_data, exp);
    endtask

    task automatic ack();
        bus.frame_ack = 1'b1;
        cyc();
        bus.frame_ack = 1'b0;
    endtask

    int base;

    initial begin
        rst = 1'b1;
        bus.rx_data = 8'd0; bus.rx_byte_received = 1'b0; bus.rx_err = 1'b0;
        bus.rd_addr = 4'd0; bus.frame_ack = 1'b0;
        repeat (3) cyc();
        check("reset_frame_ready", bus.frame_ready, 0);
        check("reset_frame_len", bus.frame_len, 0);
        check("reset_rd_data", bus.rd_data, 0);
        check("reset_rx_read", bus.rx_read, 0);
        rst = 1'b0;
        cyc();

        // Valid three-byte frame
        seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send_seq();
        check("t1_ready", bus.frame_ready, 1);
        check("t1_len", bus.frame_len, 3);
        check("t1_rx_reads", c_read, 6);
        rd(4'd0, 8'h11, "t1_rd0");
        rd(4'd1, 8'h22, "t1_rd1");
        rd(4'd2, 8'h33, "t1_rd2");
        ack();
        check("t1_ack_drop", bus.frame_ready, 0);

        // Bad checksum, then recovery
        seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
        send_seq();
        check("t2_chk_err", c_chk, 1);
        check("t2_not_ready", bus.frame_ready, 0);
        seq = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h01};
        send_seq();
        check("t2_recover", bus.frame_ready, 1);
        rd(4'd1, 8'h02, "t2_rd1");
        ack();

        // Length errors
        seq = '{8'hA5, 8'h00, 8'hA5, 8'h11};
        send_seq();
        check("t3_len_err", c_len, 2);
        check("t3_not_ready", bus.frame_ready, 0);

        // Inter-byte timeout
        seq = '{8'hA5, 8'h02, 8'h7E};
        send_seq();
        repeat (8690) cyc();
        check("t4_timeout", c_tmo, 1);
        seq = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
        send_seq();
        check("t4_ready", bus.frame_ready, 1);
        rd(4'd0, 8'h5A, "t4_rd0");

        // Overrun while held, then ack coinciding with SOF
        seq = '{8'hA5, 8'h01, 8'h66, 8'h67};
        send_seq();
        check("t5_overrun", c_ovr, 4);
        rd(4'd0, 8'h5A, "t5_held_rd0");
        base = c_ovr;
        bus.frame_ack = 1'b1; bus.rx_data = SOF; bus.rx_byte_received = 1'b1;
        cyc();
        bus.frame_ack = 1'b0; bus.rx_byte_received = 1'b0;
        cyc();
        check("t5_no_overrun", c_ovr - base, 0);
        seq = '{8'h01, 8'h77, 8'h76};
        send_seq();
        check("t5_new_frame", bus.frame_ready, 1);
        rd(4'd0, 8'h77, "t5_rd0");
        ack();
        ack();
        check("t5_ack_idle_ignored", bus.frame_ready, 0);

        // Reset mid-payload, then line error in LEN
        base = c_chk + c_len + c_line + c_tmo + c_ovr;
        seq = '{8'hA5, 8'h03, 8'h11};
        send_seq();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("t6_rst_ready", bus.frame_ready, 0);
        check("t6_rst_rd", bus.rd_data, 0);
        cyc();
        check("t6_no_errors", c_chk + c_len + c_line + c_tmo + c_ovr - base, 0);
        send(SOF, 1'b0);
        send(8'h03, 1'b1);
        check("t6_line_err", c_line, 1);
        check("t6_not_ready", bus.frame_ready, 0);
        repeat (4) cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
